// File: rtl/blink_scheduler.sv
// Round-robin owner of a single blink-period generator and LED: one requester at a time
// gets N blink periods followed by GAP_PERIODS dark periods, then a one-cycle done pulse.
module blink_scheduler #(
    parameter logic [27:0] DIVISOR     = 28'd50000000,
    parameter logic [3:0]  GAP_PERIODS = 4'd2
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [3:0]  req_in,
    input  logic [15:0] count_in,
    output logic [3:0]  grant_out,
    output logic [3:0]  done_out,
    output logic        busy_out,
    output logic        led_out
);

    localparam logic [27:0] HALF     = DIVISOR >> 1;
    localparam logic [27:0] LAST_CNT = DIVISOR - 28'd1;
    localparam logic [3:0]  LAST_GAP = GAP_PERIODS - 4'd1;

    typedef enum logic [1:0] {IDLE, BLINK, GAP} state_t;

    state_t      state_reg, state_next;
    logic [27:0] pcnt_reg, pcnt_next;
    logic [3:0]  rem_reg, rem_next;
    logic [3:0]  gcnt_reg, gcnt_next;
    logic [1:0]  last_reg, last_next;
    logic [1:0]  owner_reg, owner_next;
    logic [3:0]  grant_reg, grant_next;
    logic [3:0]  done_reg, done_next;
    logic        busy_reg, busy_next;
    logic        led_reg, led_next;

    logic [3:0]  rot_req;
    logic [3:0]  nib [4];
    logic [1:0]  pick_off;
    logic [1:0]  pick;
    logic        wrap;

    // rot_req[k] is the request of the requester k+1 places after the last owner
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_req
            assign rot_req[gi] = req_in[2'(last_reg + 2'(gi + 1))];
            assign nib[gi]     = count_in[4*gi+3:4*gi];
        end
    endgenerate

    always_comb begin
        pick_off = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (rot_req[i]) pick_off = 2'(i);
        end
        pick = last_reg + pick_off + 2'd1;
    end

    always_comb begin
        state_next = state_reg;
        pcnt_next  = pcnt_reg;
        rem_next   = rem_reg;
        gcnt_next  = gcnt_reg;
        last_next  = last_reg;
        owner_next = owner_reg;
        grant_next = grant_reg;
        done_next  = 4'd0;
        busy_next  = busy_reg;
        wrap       = (pcnt_reg == LAST_CNT);
        case (state_reg)
            IDLE: begin
                if (|req_in) begin
                    owner_next = pick;
                    rem_next   = nib[pick];
                    pcnt_next  = 28'd0;
                    gcnt_next  = 4'd0;
                    grant_next = 4'b0001 << pick;
                    busy_next  = 1'b1;
                    state_next = (nib[pick] == 4'd0) ? GAP : BLINK;
                end
            end
            BLINK: begin
                pcnt_next = wrap ? 28'd0 : pcnt_reg + 28'd1;
                if (wrap) begin
                    rem_next = rem_reg - 4'd1;
                    if (rem_reg == 4'd1) begin
                        state_next = GAP;
                        gcnt_next  = 4'd0;
                    end
                end
            end
            GAP: begin
                pcnt_next = wrap ? 28'd0 : pcnt_reg + 28'd1;
                if (wrap) begin
                    if (gcnt_reg == LAST_GAP) begin
                        state_next = IDLE;
                        done_next  = grant_reg;
                        last_next  = owner_reg;
                        grant_next = 4'd0;
                        busy_next  = 1'b0;
                    end else begin
                        gcnt_next = gcnt_reg + 4'd1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
        // Registered LED follows the counter value it will sit beside next cycle
        led_next = (state_next == BLINK) && (pcnt_next >= HALF);
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_reg <= IDLE;
            pcnt_reg  <= 28'd0;
            rem_reg   <= 4'd0;
            gcnt_reg  <= 4'd0;
            last_reg  <= 2'd3;
            owner_reg <= 2'd0;
            grant_reg <= 4'd0;
            done_reg  <= 4'd0;
            busy_reg  <= 1'b0;
            led_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            pcnt_reg  <= pcnt_next;
            rem_reg   <= rem_next;
            gcnt_reg  <= gcnt_next;
            last_reg  <= last_next;
            owner_reg <= owner_next;
            grant_reg <= grant_next;
            done_reg  <= done_next;
            busy_reg  <= busy_next;
            led_reg   <= led_next;
        end
    end

    assign grant_out = grant_reg;
    assign done_out  = done_reg;
    assign busy_out  = busy_reg;
    assign led_out   = led_reg;

endmodule

// File: tb/tb_blink_scheduler.sv
// Directed bench for blink_scheduler with DIVISOR=4, GAP_PERIODS=1; expected values hand-derived.
module tb_blink_scheduler;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic [3:0]  req_in;
    logic [15:0] count_in;
    logic [3:0]  grant_out;
    logic [3:0]  done_out;
    logic        busy_out;
    logic        led_out;

    int tests = 0;
    int fails = 0;

    always #5 clk_in = ~clk_in;

    blink_scheduler #(
        .DIVISOR(28'd4),
        .GAP_PERIODS(4'd1)
    ) dut (
        .clk_in(clk_in),
        .rst_in(rst_in),
        .req_in(req_in),
        .count_in(count_in),
        .grant_out(grant_out),
        .done_out(done_out),
        .busy_out(busy_out),
        .led_out(led_out)
    );

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    // Compares {grant, done, busy, led} against the expected tuple
    task automatic chk_out(input string tag, input logic [3:0] g, input logic [3:0] d,
                           input logic b, input logic l);
        logic [9:0] obs;
        logic [9:0] exp;
        obs = {grant_out, done_out, busy_out, led_out};
        exp = {g, d, b, l};
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed grant/done/busy/led=%b required=%b", tag, obs, exp);
        end
    endtask

    initial begin
        logic exp_led;
        logic [3:0] owner;

        // 1: reset with random requests
        rst_in   = 1'b1;
        count_in = 16'h1111;
        for (int i = 0; i < 3; i++) begin
            req_in = 4'($urandom_range(0, 15));
            step();
            chk_out($sformatf("reset_c%0d", i), 4'd0, 4'd0, 1'b0, 1'b0);
        end
        req_in = 4'd0;
        rst_in = 1'b0;
        step();
        chk_out("idle_after_reset", 4'd0, 4'd0, 1'b0, 1'b0);
        $display("[TB] reset: outputs held low");

        // 2: single burst, requester 0, count 3
        req_in   = 4'b0001;
        count_in = 16'h0003;
        step();
        for (int c = 1; c <= 16; c++) begin
            exp_led = (((c - 1) / 4) < 3) && (((c - 1) % 4) >= 2);
            chk_out($sformatf("single_c%0d", c), 4'b0001, 4'd0, 1'b1, exp_led);
            step();
        end
        chk_out("single_done", 4'd0, 4'b0001, 1'b0, 1'b0);
        req_in = 4'd0;
        step();
        chk_out("single_idle", 4'd0, 4'd0, 1'b0, 1'b0);
        $display("[TB] single burst: requester 0 count 3 done");

        // 3: arbitration order after reset
        rst_in = 1'b1;
        step();
        rst_in   = 1'b0;
        req_in   = 4'b1111;
        count_in = 16'h1111;
        step();
        for (int k = 0; k < 4; k++) begin
            for (int c = 0; c < 8; c++) begin
                exp_led = (c >= 2) && (c < 4);
                chk_out($sformatf("arb%0d_c%0d", k, c), 4'(1 << k), 4'd0, 1'b1, exp_led);
                step();
            end
            chk_out($sformatf("arb%0d_done", k), 4'd0, 4'(1 << k), 1'b0, 1'b0);
            $display("[TB] arbitration: requester %0d served", k);
            req_in[k] = 1'b0;
            step();
        end
        chk_out("arb_idle", 4'd0, 4'd0, 1'b0, 1'b0);

        // 4: zero count on requester 2
        req_in   = 4'b0100;
        count_in = 16'h0000;
        step();
        for (int c = 0; c < 4; c++) begin
            chk_out($sformatf("zero_c%0d", c), 4'b0100, 4'd0, 1'b1, 1'b0);
            step();
        end
        chk_out("zero_done", 4'd0, 4'b0100, 1'b0, 1'b0);
        req_in = 4'd0;
        step();
        $display("[TB] zero count: requester 2 gap only");

        // 5: fairness between continuously requesting 1 and 2
        req_in   = 4'b0110;
        count_in = 16'h0110;
        step();
        for (int n = 0; n < 4; n++) begin
            owner = (n % 2 == 0) ? 4'b0010 : 4'b0100;
            for (int c = 0; c < 8; c++) begin
                exp_led = (c >= 2) && (c < 4);
                chk_out($sformatf("fair%0d_c%0d", n, c), owner, 4'd0, 1'b1, exp_led);
                step();
            end
            chk_out($sformatf("fair%0d_done", n), 4'd0, owner, 1'b0, 1'b0);
            $display("[TB] fairness: burst %0d granted to mask %b", n, owner);
            if (n == 3) req_in = 4'd0;
            step();
        end
        chk_out("fair_idle", 4'd0, 4'd0, 1'b0, 1'b0);

        // 6: reset mid-BLINK
        req_in   = 4'b0011;
        count_in = 16'h0033;
        step();
        for (int c = 1; c <= 6; c++) begin
            exp_led = ((c - 1) % 4) >= 2;
            chk_out($sformatf("rstmid_c%0d", c), 4'b0001, 4'd0, 1'b1, exp_led);
            if (c < 6) step();
        end
        rst_in = 1'b1;
        step();
        chk_out("rstmid_c7", 4'd0, 4'd0, 1'b0, 1'b0);
        rst_in = 1'b0;
        step();
        chk_out("rstmid_regrant", 4'b0001, 4'd0, 1'b1, 1'b0);
        step();
        chk_out("rstmid_c9", 4'b0001, 4'd0, 1'b1, 1'b0);
        $display("[TB] reset mid-burst: re-granted to requester 0");
        req_in = 4'd0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/blink_scheduler.md
# blink_scheduler

Round-robin controller that shares one blink-period generator, and the single LED it drives, between four requesters. Each requester asks for a burst of N blinks. The block grants one requester at a time, runs the divider-style period counter for exactly N periods, then a dark gap, then signals completion. It sits between status sources (boot, error, heartbeat, user) and the board LED pin, so the LED never shows interleaved patterns.

## Interface

Parameters:
- DIVISOR, 28'd50000000, clk_in cycles per blink period; legal range 2..2^28-1.
- GAP_PERIODS, 4'd2, dark periods inserted after each burst; legal range 1..15.

Ports:
- clk_in, input, 1, the single clock; every register is updated on its rising edge.
- rst_in, input, 1, synchronous, active-high reset; sampled on the clk_in rising edge.
- req_in, input, 4, level request per requester; must be held until the matching done_out pulse.
- count_in, input, 16, packed blink counts; requester i uses bits [4i+3:4i], sampled at grant.
- grant_out, output, 4, one-hot owner of the LED; 0 when idle.
- done_out, output, 4, one-hot, one-cycle completion pulse.
- busy_out, output, 1, high while any grant is active.
- led_out, output, 1, LED drive.

## Operation

- States are IDLE, BLINK and GAP. Registers:
  - 28-bit period counter pcnt.
  - 4-bit remaining-blink counter rem.
  - 4-bit gap counter gcnt.
  - 2-bit round-robin pointer last.
  - 2-bit owner index.
- Reset (rst_in high at an edge) forces the following, regardless of current state:
  - state = IDLE; pcnt, rem and gcnt = 0; last = 3.
  - Every output register is 0: grant_out, done_out, busy_out and led_out.
- IDLE behaviour:
  - If req_in is nonzero, select the first set bit searching last+1, last+2, … modulo 4.
  - Latch that requester's count_in nibble into rem, set owner, clear pcnt.
  - If the latched count is nonzero, go to BLINK; if it is 0, go straight to GAP (no blinks).
  - If req_in is 0, stay in IDLE.
- BLINK behaviour:
  - pcnt counts 0..DIVISOR-1 and then wraps to 0.
  - led_out = 0 while pcnt < DIVISOR/2 (integer division), and 1 otherwise. This is the same phase as the team's clock divider.
  - On the wrap, rem decrements. When rem is 1 at the wrap, go to GAP with gcnt = 0.
- GAP behaviour:
  - led_out = 0 throughout. pcnt still wraps every DIVISOR cycles.
  - gcnt increments on each wrap. When gcnt == GAP_PERIODS-1 at the wrap, go to IDLE.
  - On that same transition, done_out[owner] pulses, last = owner, and grant_out is cleared.
- grant_out[owner] and busy_out are high for every BLINK and GAP cycle and low in IDLE.
- Requests and counts are only sampled in IDLE:
  - req_in dropping mid-burst is ignored; the burst runs to completion.
  - count_in changes after the grant are ignored.
- A requester still asserting req_in in the cycle done_out is high is treated as a new request. It competes under round robin; with no other requester pending it is re-served immediately.
- Only one grant and one done bit are ever set at a time.

## Timing

- All outputs are registered.
- Request to grant latency is 1 cycle: req_in is sampled at edge k, and grant_out/busy_out are high from cycle k+1.
- Burst duration is (count + GAP_PERIODS) × DIVISOR cycles of busy_out. A count of 0 gives GAP_PERIODS × DIVISOR cycles.
- done_out is high exactly during the first IDLE cycle after GAP. The next grant can start in the cycle after that, so there is a minimum of one idle cycle between bursts.
- led_out is low for the first floor(DIVISOR/2) cycles and high for the remaining DIVISOR - floor(DIVISOR/2) cycles of each BLINK period.
- Reset mid-burst takes effect at the next edge:
  - No done_out pulse is produced.
  - led_out is 0 on the following cycle.
  - Arbitration restarts at requester 0.

## Test plan

All scenarios use DIVISOR=4 and GAP_PERIODS=1.

1. Reset: hold rst_in 3 cycles with random req_in. Required: grant_out, done_out, busy_out and led_out all 0; no grant issued while in reset.
2. Single burst: req_in=0001, count_in nibble0=3, req_in raised at edge 0.
   - grant_out=0001 for cycles 1–16.
   - led_out pattern 0,0,1,1 repeated 3 times, then 0,0,0,0.
   - done_out=0001 at cycle 17 only.
3. Arbitration order: right after reset, req_in=1111 with all counts 1, each req held until its own done. Required: grants in order 0,1,2,3, each 8 cycles busy, each followed by one idle/done cycle.
4. Zero count: requester 2 with count 0. Required: grant_out=0100 for 4 cycles, led_out stays 0, then done_out=0100.
5. Fairness: req1 and req2 held high continuously with count 1. Required: grants alternate 1,2,1,2; neither is granted twice in a row.
6. Reset mid-BLINK: during scenario 2, assert rst_in at cycle 6. Required:
   - All outputs 0 at cycle 7; no done_out pulse.
   - With req_in=0011 still high, the next grant after reset release goes to requester 0.
